// File: rtl/tea_encrypt_iterative.sv
// tea_encrypt_iterative
//   Iterative TEA encryptor: one full TEA cycle (v0 half-round followed by
//   the v1 half-round) per enabled clock, ROUNDS cycles per block.
//   Valid/ready handshake on both sides; the key is captured with each block.
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous, active-high reset
//   ena        global enable; when low all state freezes, no handshake completes
//   in_valid   plaintext/key presented
//   in_ready   block can be accepted this cycle (combinational)
//   inBlock64  plaintext, [63:32]=v0, [31:0]=v1
//   key        [127:96]=k0, [95:64]=k1, [63:32]=k2, [31:0]=k3
//   out_valid  outBlock64 holds a finished ciphertext
//   out_ready  downstream consumes outBlock64
//   outBlock64 ciphertext, [63:32]=v0, [31:0]=v1
//   busy       high while rounds are being computed
module tea_encrypt_iterative #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t        state;
  logic [31:0]   v0, v1, sum;
  logic [5:0]    cnt;
  logic [127:0]  key_q;
  logic [63:0]   out_q;
  logic          out_valid_q;
  logic          busy_q;

  logic [31:0]   k0, k1, k2, k3;
  logic [31:0]   sum_n, v0_n, v1_n;
  logic          accept;

  always_comb begin
    k0    = key_q[127:96];
    k1    = key_q[95:64];
    k2    = key_q[63:32];
    k3    = key_q[31:0];
    sum_n = sum + DELTA;
    v0_n  = v0   + (((v1   << 4) + k0) ^ (v1   + sum_n) ^ ((v1   >> 5) + k1));
    v1_n  = v1   + (((v0_n << 4) + k2) ^ (v0_n + sum_n) ^ ((v0_n >> 5) + k3));
  end

  // Gated by rst so in_ready is low for the whole reset pulse, not just after it.
  assign in_ready = ~rst & ena & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign out_valid  = out_valid_q;
  assign outBlock64 = out_q;
  assign busy       = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      v0          <= '0;
      v1          <= '0;
      sum         <= '0;
      cnt         <= '0;
      key_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        // Accept in DONE implies out_ready, so this edge also consumes the
        // pending result: straight back to RUN with no bubble.
        v0          <= inBlock64[63:32];
        v1          <= inBlock64[31:0];
        key_q       <= key;
        sum         <= '0;
        cnt         <= '0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
        state       <= RUN;
      end else begin
        case (state)
          RUN: begin
            sum <= sum_n;
            v0  <= v0_n;
            v1  <= v1_n;
            cnt <= cnt + 6'd1;
            if (cnt == LAST) begin
              out_q       <= {v0_n, v1_n};
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state       <= DONE;
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state       <= IDLE;
            end
          end
          IDLE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tea_encrypt_iterative.sv
// tb_tea_encrypt_iterative
//   Three encryptors (ROUNDS = 32, 1, 63) share clk/rst/ena; each has its own
//   handshake and data signals. A negedge monitor keeps a scoreboard of
//   expected ciphertexts from a software TEA model; directed sequences cover
//   latency, backpressure, zero-bubble back-to-back, ena gating and reset.
module tb_tea_encrypt_iterative;

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [63:0] KAT   = 64'h41EA3A0A_94BAA940;

  logic         clk = 1'b0;
  logic         rst, ena;
  logic [2:0]   in_valid, out_ready;
  logic [2:0]   in_ready, out_valid, busy;
  logic [63:0]  pt_s  [3];
  logic [127:0] key_s [3];
  logic [63:0]  ct_s  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tea_encrypt_iterative #(
      .ROUNDS((g == 0) ? 32 : ((g == 1) ? 1 : 63)),
      .DELTA (DELTA)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .inBlock64 (pt_s[g]),
      .key       (key_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .outBlock64(ct_s[g]),
      .busy      (busy[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic int unsigned rounds_of(int i);
    return (i == 0) ? 32 : ((i == 1) ? 1 : 63);
  endfunction

  function automatic logic [63:0] tea_enc(logic [63:0] pt, logic [127:0] k, int unsigned r);
    logic [31:0] a, b, s;
    a = pt[63:32]; b = pt[31:0]; s = 0;
    for (int unsigned n = 0; n < r; n++) begin
      s = s + DELTA;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32])  ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] tea_dec(logic [63:0] ct, logic [127:0] k, int unsigned r);
    logic [31:0] a, b, s;
    a = ct[63:32]; b = ct[31:0]; s = DELTA * r;
    for (int unsigned n = 0; n < r; n++) begin
      b = b - (((a << 4) + k[63:32])  ^ (a + s) ^ ((a >> 5) + k[31:0]));
      a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      s = s - DELTA;
    end
    return {a, b};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    int          idx;
    logic [63:0] ct;
  } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    sb_t e;
    if (!rst && ena) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sbq.size() == 0) check("sb_unexpected_output", 1, 0);
          else begin
            e = sbq.pop_front();
            check("sb_inst", i, e.idx);
            check("sb_ct", ct_s[i], e.ct);
          end
        end
        if (in_valid[i] && in_ready[i]) begin
          e.idx = i;
          e.ct  = tea_enc(pt_s[i], key_s[i], rounds_of(i));
          sbq.push_back(e);
        end
      end
    end
  end

  // All tasks are entered and left at posedge+#1.
  task automatic send(int i, logic [63:0] pt, logic [127:0] k);
    int t = 0;
    while (!in_ready[i] && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_timeout", in_ready[i], 1);
    pt_s[i] = pt; key_s[i] = k; in_valid[i] = 1'b1;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    check("busy_after_accept", busy[i], 1);
  endtask

  task automatic wait_done(int i, output int cyc);
    cyc = 0;
    while (!out_valid[i] && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("done_timeout", out_valid[i], 1);
  endtask

  task automatic run_block(int i, logic [63:0] pt, logic [127:0] k);
    int cyc;
    send(i, pt, k);
    wait_done(i, cyc);
    check("latency", cyc, rounds_of(i));
    check("round_trip", tea_dec(ct_s[i], k, rounds_of(i)), pt);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    logic [63:0]  ct;
  } vec_t;
  vec_t vt[5];

  initial begin
    int          cyc;
    logic [63:0] snap;

    vt[0] = '{64'h0, 128'h0, KAT};
    vt[1] = '{64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 64'h0};
    vt[2] = '{64'hFFFFFFFF_FFFFFFFF, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 64'h0};
    vt[3] = '{64'h80000000_00000001, 128'h00000001_80000000_DEADBEEF_0BADF00D, 64'h0};
    vt[4] = '{64'h0, 128'h00000000_00000000_00000000_00000001, 64'h0};
    for (int v = 1; v < 5; v++) vt[v].ct = tea_enc(vt[v].pt, vt[v].key, 32);

    rst = 1'b1; ena = 1'b1; in_valid = '0; out_ready = '0;
    for (int i = 0; i < 3; i++) begin pt_s[i] = '0; key_s[i] = '0; end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", in_ready[i], 0);
      check("rst_out_valid", out_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_out", ct_s[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready[0], 1);

    // Known-answer vector with exact latency and return to IDLE
    out_ready[0] = 1'b1;
    send(0, 64'h0, 128'h0);
    wait_done(0, cyc);
    check("kat_latency", cyc, 32);
    check("kat_ct", ct_s[0], KAT);
    check("kat_busy_done", busy[0], 0);
    @(posedge clk); #1;
    check("kat_idle_out_valid", out_valid[0], 0);
    check("kat_idle_in_ready", in_ready[0], 1);
    check("kat_out_retained", ct_s[0], KAT);

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      send(0, vt[v].pt, vt[v].key);
      wait_done(0, cyc);
      check("vec_latency", cyc, 32);
      check("vec_ct", ct_s[0], vt[v].ct);
      @(posedge clk); #1;
    end

    // Backpressure, then consume coinciding with the next accept
    out_ready[0] = 1'b0;
    send(0, vt[1].pt, vt[1].key);
    wait_done(0, cyc);
    snap = ct_s[0];
    check("bp_ct", snap, vt[1].ct);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid[0], 1);
      check("bp_stable", ct_s[0], snap);
      check("bp_in_ready", in_ready[0], 0);
    end
    pt_s[0] = vt[2].pt; key_s[0] = vt[2].key;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("b2b_busy", busy[0], 1);
    check("b2b_out_valid_fell", out_valid[0], 0);
    check("b2b_out_retained", ct_s[0], snap);
    wait_done(0, cyc);
    check("b2b_latency", cyc, 32);
    check("b2b_ct", ct_s[0], vt[2].ct);
    @(posedge clk); #1;

    // ena gating mid-RUN
    send(0, 64'h0, 128'h0);
    repeat (10) begin @(posedge clk); #1; end
    ena = 1'b0;
    for (int n = 0; n < 7; n++) begin
      check("ena_in_ready", in_ready[0], 0);
      check("ena_busy_held", busy[0], 1);
      check("ena_no_output", out_valid[0], 0);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    wait_done(0, cyc);
    check("ena_latency", 10 + 7 + cyc, 39);
    check("ena_ct", ct_s[0], KAT);

    // ena=0 in DONE: out_ready ignored, out_valid held
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("ena_done_held", out_valid[0], 1);
    check("ena_done_ct", ct_s[0], KAT);
    ena = 1'b1;
    @(posedge clk); #1;
    check("ena_done_consumed", out_valid[0], 0);

    // Reset mid-RUN
    send(0, vt[3].pt, vt[3].key);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_out", ct_s[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_in_ready", in_ready[0], 0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 64'h0, 128'h0);
    wait_done(0, cyc);
    check("post_rst_latency", cyc, 32);
    check("post_rst_ct", ct_s[0], KAT);
    @(posedge clk); #1;

    // Random round-trip for ROUNDS = 32, 1, 63
    for (int i = 0; i < 3; i++) begin
      out_ready[i] = 1'b1;
      for (int n = 0; n < 100; n++)
        run_block(i, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (2) begin @(posedge clk); #1; end
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
